// File: rtl/fpu_issue_if.sv
// Bundle of pipeline request, FPU and writeback signals around the FPU issue sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding pipeline and FPU.
interface fpu_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [15:0] req_op1;
  logic [15:0] req_op2;
  logic [3:0]  req_rd;
  logic        flush;
  logic        fpu_en;
  logic [4:0]  fpu_instr;
  logic [15:0] fpu_op1;
  logic [15:0] fpu_op2;
  logic [15:0] fpu_result;
  logic        fpu_done;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_err;
  logic        busy;
  logic [3:0]  busy_rd;
  logic [7:0]  err_count;

  modport slave (
    input  req_valid, req_op, req_op1, req_op2, req_rd, flush, fpu_result, fpu_done,
    output req_ready, fpu_en, fpu_instr, fpu_op1, fpu_op2,
           wb_valid, wb_rd, wb_data, wb_err, busy, busy_rd, err_count
  );

  modport master (
    output req_valid, req_op, req_op1, req_op2, req_rd, flush, fpu_result, fpu_done,
    input  req_ready, fpu_en, fpu_instr, fpu_op1, fpu_op2,
           wb_valid, wb_rd, wb_data, wb_err, busy, busy_rd, err_count
  );
endinterface

// File: rtl/fpu_issue.sv
// Issue/writeback sequencer in front of the 16-bit FPU: one op in flight, done-or-timeout
// completion, single-cycle tagged writeback pulse.
module fpu_issue #(
  parameter int TIMEOUT = 16
) (
  input logic        clk,
  input logic        reset,
  fpu_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t      state, state_nxt;
  logic [4:0]  op_q;
  logic [15:0] op1_q, op2_q;
  logic [3:0]  rd_q;
  logic [7:0]  cnt;
  logic [15:0] wb_data_q;
  logic        wb_err_q;
  logic [7:0]  err_count_q;
  logic        ready, accept, legal, timeout;

  assign legal   = (bus.req_op >= 5'h11) && (bus.req_op <= 5'h16);
  assign accept  = bus.req_valid && ready;
  assign timeout = (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = !bus.flush;
        if (accept) state_nxt = legal ? ISSUE : WB;
      end
      // fpu_done is deliberately not looked at here: it may still be high from the last op
      ISSUE:   state_nxt = bus.flush ? IDLE : WAIT;
      WAIT: begin
        if (bus.flush)                     state_nxt = IDLE;
        else if (bus.fpu_done || timeout)  state_nxt = WB;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      cnt         <= '0;
      wb_data_q   <= '0;
      wb_err_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.req_op;
        op1_q <= bus.req_op1;
        op2_q <= bus.req_op2;
        rd_q  <= bus.req_rd;
        if (!legal) begin
          wb_data_q <= '0;
          wb_err_q  <= 1'b1;
        end
      end
      if (state == ISSUE) cnt <= '0;
      // done beats timeout when both land on the same edge
      if (state == WAIT && !bus.flush) begin
        if (bus.fpu_done) begin
          wb_data_q <= bus.fpu_result;
          wb_err_q  <= 1'b0;
        end else if (timeout) begin
          wb_data_q <= '0;
          wb_err_q  <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
      if (state == WB && !bus.flush && wb_err_q && err_count_q != 8'hff)
        err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.req_ready = ready;
  assign bus.fpu_en    = (state == ISSUE) || (state == WAIT);
  assign bus.fpu_instr = op_q;
  assign bus.fpu_op1   = op1_q;
  assign bus.fpu_op2   = op2_q;
  assign bus.wb_valid  = (state == WB);
  assign bus.wb_rd     = (state == WB) ? rd_q : 4'd0;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_err    = wb_err_q;
  assign bus.busy      = (state != IDLE);
  assign bus.busy_rd   = (state != IDLE) ? rd_q : 4'd0;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: transaction-age reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with a latency-programmable FPU stub.
module tb_fpu_issue;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fpu_issue_if bus();
  fpu_issue #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // FPU stub: done once en has been high for lat edges, or forced high
  int          en_cnt = 0;
  int          lat = 1;
  bit          force_done = 0;
  logic [15:0] res = '0;
  always @(posedge clk) en_cnt <= (bus.fpu_en === 1'b1) ? en_cnt + 1 : 0;
  assign bus.fpu_done   = force_done || (en_cnt >= lat);
  assign bus.fpu_result = res;

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: m_e counts edges since accept; edge 1 leaves the issue cycle
  bit          m_busy = 0, m_wb = 0, m_err = 0;
  int          m_e = 0;
  logic [15:0] m_data = '0, m_o1 = '0, m_o2 = '0;
  logic [4:0]  m_op = '0;
  logic [3:0]  m_rd = '0;
  logic [7:0]  m_ec = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_wb = 0; m_err = 0; m_e = 0; m_data = '0;
      m_o1 = '0; m_o2 = '0; m_op = '0; m_rd = '0; m_ec = '0;
    end else if (!m_busy) begin
      if (bus.req_valid && !bus.flush) begin
        m_busy = 1; m_op = bus.req_op; m_o1 = bus.req_op1; m_o2 = bus.req_op2; m_rd = bus.req_rd;
        if (bus.req_op >= 5'h11 && bus.req_op <= 5'h16) begin
          m_wb = 0; m_e = 1;
        end else begin
          m_wb = 1; m_data = '0; m_err = 1;
        end
      end
    end else if (bus.flush) begin
      m_busy = 0; m_wb = 0;
    end else if (m_wb) begin
      m_busy = 0; m_wb = 0;
      if (m_err && m_ec != 8'd255) m_ec = m_ec + 8'd1;
    end else begin
      if (m_e >= 2 && bus.fpu_done) begin
        m_wb = 1; m_data = bus.fpu_result; m_err = 0;
      end else if (m_e == TO + 1) begin
        m_wb = 1; m_data = '0; m_err = 1;
      end
      m_e++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", 16'(bus.req_ready), 16'(!m_busy && !bus.flush));
      chk("fpu_en",    16'(bus.fpu_en),    16'(m_busy && !m_wb));
      chk("wb_valid",  16'(bus.wb_valid),  16'(m_busy && m_wb));
      chk("wb_rd",     16'(bus.wb_rd),     16'((m_busy && m_wb) ? m_rd : 4'd0));
      chk("wb_data",   bus.wb_data,        m_data);
      chk("wb_err",    16'(bus.wb_err),    16'(m_err));
      chk("busy",      16'(bus.busy),      16'(m_busy));
      chk("busy_rd",   16'(bus.busy_rd),   16'(m_busy ? m_rd : 4'd0));
      chk("err_count", 16'(bus.err_count), 16'(m_ec));
      chk("fpu_instr", 16'(bus.fpu_instr), 16'(m_op));
      chk("fpu_op1",   bus.fpu_op1,        m_o1);
      chk("fpu_op2",   bus.fpu_op2,        m_o2);
    end
  end

  task automatic send(logic [4:0] op, logic [15:0] o1, logic [15:0] o2, logic [3:0] rd);
    @(posedge clk); #2;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_op1 = o1; bus.req_op2 = o2; bus.req_rd = rd;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
  endtask

  int o_rr, o_en, o_wbv, o_first;
  logic [15:0] o_data;
  logic [3:0]  o_rd, o_brd;
  logic        o_err;
  task automatic obs(int n);
    o_rr = 0; o_en = 0; o_wbv = 0; o_first = 0; o_data = 'x; o_rd = 'x; o_brd = 'x; o_err = 1'bx;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (!bus.req_ready) o_rr++;
      if (bus.fpu_en) o_en++;
      if (bus.wb_valid) begin
        o_wbv++;
        if (o_first == 0) o_first = i;
        o_rd = bus.wb_rd; o_data = bus.wb_data; o_err = bus.wb_err; o_brd = bus.busy_rd;
      end
    end
  endtask

  initial begin
    bus.req_valid = 0; bus.req_op = '0; bus.req_op1 = '0; bus.req_op2 = '0; bus.req_rd = '0;
    bus.flush = 0;
    @(posedge clk); started = 1;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("rst_req_ready", 16'(bus.req_ready), 16'd1);
    chk("rst_busy",      16'(bus.busy),      16'd0);
    chk("rst_err_count", 16'(bus.err_count), 16'd0);

    // ITOF with a one-cycle FPU
    lat = 1; res = 16'h4120;
    send(5'h13, 16'h0000, 16'h0005, 4'd3);
    obs(6);
    chk("itof_ready_low", 16'(o_rr), 16'd3);
    chk("itof_en_cycles", 16'(o_en), 16'd2);
    chk("itof_wb_pulses", 16'(o_wbv), 16'd1);
    chk("itof_wb_at",     16'(o_first), 16'd3);
    chk("itof_wb_rd",     16'(o_rd), 16'd3);
    chk("itof_wb_data",   o_data, 16'h4120);
    chk("itof_wb_err",    16'(o_err), 16'd0);

    // MULF with a stale done already high
    force_done = 1; res = 16'hdead;
    send(5'h14, 16'h400a, 16'h3f63, 4'd5);
    res = 16'h4178;
    obs(6);
    chk("mulf_wb_at",   16'(o_first), 16'd3);
    chk("mulf_wb_data", o_data, 16'h4178);
    chk("mulf_en",      16'(o_en), 16'd2);
    force_done = 0;

    // RECF with an FPU that never finishes
    lat = 1000;
    send(5'h15, 16'h1111, 16'h2222, 4'd2);
    obs(22);
    chk("to_en_cycles", 16'(o_en), 16'd17);
    chk("to_wb_at",     16'(o_first), 16'd18);
    chk("to_wb_data",   o_data, 16'h0000);
    chk("to_wb_err",    16'(o_err), 16'd1);
    chk("to_err_count", 16'(bus.err_count), 16'd1);

    // illegal opcode: straight to writeback
    send(5'h08, 16'h1, 16'h2, 4'd7);
    obs(4);
    chk("ill_en",        16'(o_en), 16'd0);
    chk("ill_wb_at",     16'(o_first), 16'd1);
    chk("ill_wb_rd",     16'(o_rd), 16'd7);
    chk("ill_busy_rd",   16'(o_brd), 16'd7);
    chk("ill_wb_err",    16'(o_err), 16'd1);
    chk("ill_err_count", 16'(bus.err_count), 16'd2);

    // flush in the third WAIT cycle of an FTOI
    send(5'h12, 16'h1234, 16'h0000, 4'd9);
    repeat (3) @(posedge clk);
    #2 bus.flush = 1;
    @(posedge clk); #2 bus.flush = 0;
    obs(5);
    chk("fl_wb_pulses", 16'(o_wbv), 16'd0);
    chk("fl_en",        16'(o_en), 16'd0);
    chk("fl_ready_low", 16'(o_rr), 16'd0);
    chk("fl_err_count", 16'(bus.err_count), 16'd2);
    lat = 1; res = 16'h4000;
    send(5'h13, 16'h0000, 16'h0002, 4'd4);
    obs(6);
    chk("fl2_wb_pulses", 16'(o_wbv), 16'd1);
    chk("fl2_wb_data",   o_data, 16'h4000);
    chk("fl2_wb_rd",     16'(o_rd), 16'd4);
    chk("fl2_wb_err",    16'(o_err), 16'd0);

    // error counter saturation
    repeat (260) send(5'h00, 16'h0, 16'h0, 4'd1);
    obs(3);
    chk("sat_err_count", 16'(bus.err_count), 16'd255);

    // reset mid-WAIT together with flush
    lat = 1000;
    send(5'h13, 16'h0abc, 16'h0007, 4'd6);
    repeat (3) @(posedge clk);
    #2 begin reset = 1; bus.flush = 1; end
    @(posedge clk); #2 begin reset = 0; bus.flush = 0; end
    @(negedge clk);
    chk("rr_req_ready", 16'(bus.req_ready), 16'd1);
    chk("rr_fpu_en",    16'(bus.fpu_en), 16'd0);
    chk("rr_busy",      16'(bus.busy), 16'd0);
    chk("rr_wb_valid",  16'(bus.wb_valid), 16'd0);
    chk("rr_wb_data",   bus.wb_data, 16'h0000);
    chk("rr_err_count", 16'(bus.err_count), 16'd0);
    chk("rr_fpu_op1",   bus.fpu_op1, 16'h0000);

    // randomized traffic
    repeat (4000) begin
      @(posedge clk); #2;
      bus.req_valid = 1'($urandom % 2);
      bus.req_op    = ($urandom % 4 == 0) ? 5'($urandom % 32) : 5'(5'h11 + $urandom % 6);
      bus.req_op1   = 16'($urandom);
      bus.req_op2   = 16'($urandom);
      bus.req_rd    = 4'($urandom);
      bus.flush     = ($urandom % 40 == 0);
      reset         = ($urandom % 600 == 0);
      force_done    = ($urandom % 8 == 0);
      if (!bus.fpu_en) lat = int'($urandom_range(1, 20));
      res           = 16'($urandom);
    end
    @(posedge clk); #2;
    bus.req_valid = 0; bus.flush = 0; reset = 0; force_done = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
